// File: rtl/wave_gen_nco.sv
// rtl/wave_gen_nco.sv - NCO waveform generator: sine/square/triangle/sawtooth, 3-stage pipeline
// Optional amplitude scaling in stage C is enabled by defining WAVE_AMP_SCALE_EN.
module wave_gen_nco #(
    parameter int PHASE_W  = 32,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter     LUT_FILE = "sine_quarter.mem"
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               phase_clr,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [ADDR_W-1:0]  phase_off,
    input  logic [1:0]         mode,
    input  logic [DATA_W-1:0]  amp,
    output logic [DATA_W-1:0]  wave_out,
    output logic               out_valid
);

    localparam int QN = 2 ** (ADDR_W - 2);
    localparam logic [DATA_W-1:0] PK = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W-1){1'b0}}};
    localparam longint SIN_ONE = 64'sd1073741824;
    localparam longint TWO_PI  = 64'sd6746518852;
    localparam longint PK_L    = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam unused_lut_file = LUT_FILE;

    localparam logic [1:0] MODE_SINE = 2'd0;
    localparam logic [1:0] MODE_SQR  = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;

    // Quarter-wave table is computed at elaboration (fixed-point Taylor series,
    // Q30) so no external memory file is needed at build time.
    function automatic logic [DATA_W-1:0] sin_q(input int k);
        longint x;
        longint term;
        longint sum;
        x    = (longint'(k) * TWO_PI) / longint'(4 * QN);
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = ((-((term * x) / SIN_ONE)) * x) / SIN_ONE / longint'(2 * n * (2 * n + 1));
            sum  = sum + term;
        end
        return DATA_W'((sum * PK_L + SIN_ONE / 2) / SIN_ONE);
    endfunction

    logic [DATA_W-1:0] lut [QN];

    for (genvar g = 0; g < QN; g++) begin : g_lut
        localparam logic [DATA_W-1:0] LUT_VAL = sin_q(g);
        assign lut[g] = LUT_VAL;
    end

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] acc_used;
    logic [ADDR_W-1:0]  p_next;

    assign acc_used = phase_clr ? '0 : acc;
    assign p_next   = acc_used[PHASE_W-1 -: ADDR_W] + phase_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (phase_clr) begin
            acc <= en ? ftw : '0;
        end else if (en) begin
            acc <= acc + ftw;
        end
    end

    // Stage A: phase plus per-sample controls
    logic [ADDR_W-1:0] p_a;
    logic [1:0]        mode_a;
    logic [DATA_W-1:0] amp_a;
    logic              valid_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_a     <= '0;
            mode_a  <= '0;
            amp_a   <= '0;
            valid_a <= 1'b0;
        end else begin
            valid_a <= en;
            if (en) begin
                p_a    <= p_next;
                mode_a <= mode;
                amp_a  <= amp;
            end
        end
    end

    // Stage B: quadrant fold and mode select
    logic [1:0]        quad;
    logic [ADDR_W-3:0] qi;
    logic [ADDR_W-3:0] lut_idx;
    logic [DATA_W-1:0] sine_mag;
    logic [ADDR_W-2:0] tri_t;
    logic [DATA_W-1:0] raw_next;

    always_comb begin
        quad     = p_a[ADDR_W-1 -: 2];
        qi       = p_a[ADDR_W-3:0];
        lut_idx  = quad[0] ? ('0 - qi) : qi;
        sine_mag = (quad[0] && (qi == '0)) ? PK : lut[lut_idx];
        tri_t    = p_a[ADDR_W-1] ? ~p_a[ADDR_W-2:0] : p_a[ADDR_W-2:0];
        case (mode_a)
            MODE_SINE: raw_next = quad[1] ? ('0 - sine_mag) : sine_mag;
            MODE_SQR:  raw_next = p_a[ADDR_W-1] ? ('0 - PK) : PK;
            MODE_TRI:  raw_next = (DATA_W'(tri_t) << (DATA_W - ADDR_W + 1)) ^ MSB;
            default:   raw_next = (DATA_W'(p_a) << (DATA_W - ADDR_W)) ^ MSB;
        endcase
    end

    logic [DATA_W-1:0] raw_b;
    logic [DATA_W-1:0] amp_b;
    logic              valid_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_b   <= '0;
            amp_b   <= '0;
            valid_b <= 1'b0;
        end else begin
            valid_b <= valid_a;
            if (valid_a) begin
                raw_b <= raw_next;
                amp_b <= amp_a;
            end
        end
    end

    // Stage C: optional gain, otherwise a plain register
    logic [DATA_W-1:0] scaled;

`ifdef WAVE_AMP_SCALE_EN
    logic signed [2*DATA_W:0] prod;
    logic signed [2*DATA_W:0] prod_sh;
    always_comb begin
        prod    = $signed(raw_b) * $signed({1'b0, amp_b});
        prod_sh = prod >>> DATA_W;
        scaled  = prod_sh[DATA_W-1:0];
    end
`else
    logic unused_amp;
    assign unused_amp = ^amp_b;
    assign scaled     = raw_b;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wave_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid_b;
            if (valid_b) begin
                wave_out <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_wave_gen_nco.sv
// tb/tb_wave_gen_nco.sv - directed table-driven bench for wave_gen_nco
module tb_wave_gen_nco;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        phase_clr = 1'b0;
    logic [31:0] ftw = 32'd1 << 22;
    logic [9:0]  phase_off = '0;
    logic [1:0]  mode = '0;
    logic [15:0] amp = '0;
    logic [15:0] wave_out;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    int cap[$];

    wave_gen_nco dut (
        .clk(clk), .reset(reset), .en(en), .phase_clr(phase_clr), .ftw(ftw),
        .phase_off(phase_off), .mode(mode), .amp(amp),
        .wave_out(wave_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    mode;
        int    off;
        int    amp;
        int    k;
        int    exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sout();
        return int'($signed(wave_out));
    endfunction

    task automatic run_stream(input int m, input int off, input int a, input int f, input int n);
        reset = 1'b1; en = 1'b0; phase_clr = 1'b0;
        tick(); tick();
        mode = 2'(m); phase_off = 10'(off); amp = 16'(a); ftw = 32'(f);
        reset = 1'b0; en = 1'b1;
        cap.delete();
        for (int c = 0; c < n + 10 && cap.size() < n; c++) begin
            @(negedge clk);
            if (out_valid) cap.push_back(sout());
            tick();
        end
        en = 1'b0;
        if (cap.size() < n) check("stream_timeout", cap.size(), n);
    endtask

    initial begin
        int first_valid;
        int v0;
        int v1;
        int cur_m, cur_off, cur_amp;
        int en_pat[70];
        int clr_pat[70];
        int ov[75];
        int wv[75];
        int model_k;
        int exp_s[$];

        vecs.push_back('{"sine_k0",     0, 0, 0,      0,      0});
        vecs.push_back('{"sine_k1",     0, 0, 0,      1,    201});
        vecs.push_back('{"sine_k128",   0, 0, 0,    128,  23170});
        vecs.push_back('{"sine_k256",   0, 0, 0,    256,  32767});
        vecs.push_back('{"sine_k384",   0, 0, 0,    384,  23170});
        vecs.push_back('{"sine_k512",   0, 0, 0,    512,      0});
        vecs.push_back('{"sine_k640",   0, 0, 0,    640, -23170});
        vecs.push_back('{"sine_k768",   0, 0, 0,    768, -32767});
        vecs.push_back('{"sine_k1024",  0, 0, 0,   1024,      0});
        vecs.push_back('{"sine_k1280",  0, 0, 0,   1280,  32767});
        vecs.push_back('{"saw_k0",      3, 0, 0,      0, -32768});
        vecs.push_back('{"saw_k1",      3, 0, 0,      1, -32704});
        vecs.push_back('{"saw_k1023",   3, 0, 0,   1023,  32704});
        vecs.push_back('{"tri_k0",      2, 0, 0,      0, -32768});
        vecs.push_back('{"tri_k511",    2, 0, 0,    511,  32640});
        vecs.push_back('{"tri_k512",    2, 0, 0,    512,  32640});
        vecs.push_back('{"tri_k1023",   2, 0, 0,   1023, -32768});
        vecs.push_back('{"sqr_k0",      1, 256, 0,    0,  32767});
        vecs.push_back('{"sqr_k255",    1, 256, 0,  255,  32767});
        vecs.push_back('{"sqr_k256",    1, 256, 0,  256, -32767});
        vecs.push_back('{"sqr_k767",    1, 256, 0,  767, -32767});
        vecs.push_back('{"sqr_k768",    1, 256, 0,  768,  32767});
`ifdef WAVE_AMP_SCALE_EN
        vecs.push_back('{"amp_k256",    0, 0, 32768, 256,  16383});
        vecs.push_back('{"amp_k768",    0, 0, 32768, 768, -16384});
`else
        vecs.push_back('{"amp_k256",    0, 0, 32768, 256,  32767});
        vecs.push_back('{"amp_k768",    0, 0, 32768, 768, -32767});
`endif

        // reset state and first-sample latency
        tick(); tick();
        @(negedge clk);
        check("reset_valid", int'(out_valid), 0);
        check("reset_wave", sout(), 0);
        tick();
        reset = 1'b0; en = 1'b1;
        first_valid = -1; v0 = 99999;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid && first_valid < 0) begin
                first_valid = c;
                v0 = sout();
            end
            tick();
        end
        check("latency", first_valid, 3);
        check("first_sample", v0, 0);

        // table-driven vectors; a stream is rerun only when its configuration changes
        cur_m = -1; cur_off = -1; cur_amp = -1;
        foreach (vecs[i]) begin
            if (vecs[i].mode != cur_m || vecs[i].off != cur_off || vecs[i].amp != cur_amp) begin
                cur_m = vecs[i].mode; cur_off = vecs[i].off; cur_amp = vecs[i].amp;
                run_stream(cur_m, cur_off, cur_amp, 32'd1 << 22, 1282);
            end
            if (vecs[i].k < cap.size()) check(vecs[i].name, cap[vecs[i].k], vecs[i].exp);
            else check(vecs[i].name, -1, vecs[i].exp);
        end

        // en gap of 5 cycles, phase_clr with en=1, phase_clr with en=0 (sawtooth)
        for (int c = 0; c < 70; c++) begin
            en_pat[c]  = (c >= 60 || (c >= 20 && c < 25) || c == 40) ? 0 : 1;
            clr_pat[c] = (c == 30 || c == 40) ? 1 : 0;
        end
        reset = 1'b1; en = 1'b0; tick(); tick();
        mode = 2'd3; phase_off = '0; ftw = 32'd1 << 22; reset = 1'b0;
        cap.delete();
        for (int c = 0; c < 75; c++) begin
            en = (c < 70) ? en_pat[c][0] : 1'b0;
            phase_clr = (c < 70) ? clr_pat[c][0] : 1'b0;
            @(negedge clk);
            ov[c] = int'(out_valid);
            wv[c] = sout();
            if (out_valid) cap.push_back(sout());
            tick();
        end
        en = 1'b0; phase_clr = 1'b0;
        model_k = 0;
        for (int c = 0; c < 70; c++) begin
            if (clr_pat[c] != 0) begin
                if (en_pat[c] != 0) exp_s.push_back(-32768);
                model_k = en_pat[c];
            end else if (en_pat[c] != 0) begin
                exp_s.push_back(-32768 + 64 * model_k);
                model_k++;
            end
        end
        for (int c = 3; c < 73; c++) begin
            check($sformatf("gap_valid_c%0d", c), ov[c], en_pat[c-3]);
            if (ov[c] == 0 && c >= 4) check($sformatf("gap_hold_c%0d", c), wv[c], wv[c-1]);
        end
        check("gap_count", cap.size(), exp_s.size());
        for (int j = 0; j < exp_s.size() && j < cap.size(); j++)
            check($sformatf("seq_s%0d", j), cap[j], exp_s[j]);
        if (cap.size() > 36) begin
            check("gap_resume", cap[20], -31488);
            check("clr_en1_s0", cap[25], -32768);
            check("clr_en1_s1", cap[26], -32704);
            check("pre_clr_en0", cap[34], -32192);
            check("clr_en0_s0", cap[35], -32768);
            check("clr_en0_s1", cap[36], -32704);
        end

        // reset asserted mid-run
        reset = 1'b0; en = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midreset_valid", int'(out_valid), 0);
        check("midreset_wave", sout(), 0);
        tick();
        reset = 1'b0;
        first_valid = -1; v0 = 99999; v1 = 99999;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first_valid < 0) begin
                    first_valid = c;
                    v0 = sout();
                end else if (c == first_valid + 1) begin
                    v1 = sout();
                end
            end
            tick();
        end
        check("restart_latency", first_valid, 3);
        check("restart_s0", v0, -32768);
        check("restart_s1", v1, -32704);

        // ftw = 0: constant phase, sample repeats
        run_stream(3, 5, 0, 0, 4);
        for (int j = 0; j < cap.size(); j++) check($sformatf("ftw0_s%0d", j), cap[j], -32448);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_gen_nco.md
# wave_gen_nco

Parametrised multi-mode waveform generator with an internal phase accumulator (NCO) and a quarter-wave sine LUT. It produces signed samples for four waveform modes from a frequency tuning word, with a per-sample phase offset, optional amplitude scaling and a valid-qualified 3-stage pipeline. It sits where the fixed 10-bit, externally addressed sine LUT sat, feeding the FIR/IIR filter chain.

## Interface
- PHASE_W, 32: phase accumulator width.
- ADDR_W, 10: phase bits per full cycle used for lookup (2^ADDR_W points per period); ADDR_W >= 3, ADDR_W <= DATA_W.
- DATA_W, 16: signed output sample width.
- LUT_FILE, "sine_quarter.mem": hex init file, 2^(ADDR_W-2) entries of DATA_W bits.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  sample strobe; one sample is generated per cycle with en=1.
- phase_clr  in  1  clears the accumulator (priority over accumulate).
- ftw  in  PHASE_W  frequency tuning word (unsigned phase increment).
- phase_off  in  ADDR_W  phase offset added to the lookup phase, modulo 2^ADDR_W.
- mode  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
- amp  in  DATA_W  unsigned amplitude, gain = amp/2^DATA_W (used only with WAVE_AMP_SCALE_EN).
- wave_out  out  DATA_W  signed sample.
- out_valid  out  1  wave_out holds a new sample this cycle.

## Operation
- acc (PHASE_W) is the phase accumulator. Per cycle: phase_clr=1 -> acc <= en ? ftw : 0; else en=1 -> acc <= acc + ftw (wraps mod 2^PHASE_W); else hold.
- Sample phase p = (acc_used[PHASE_W-1 -: ADDR_W] + phase_off) mod 2^ADDR_W, where acc_used = 0 if phase_clr=1, else the current acc.
- mode and amp are captured with p in stage A and travel with that sample. Mid-stream changes affect only later samples.
- N = 2^ADDR_W, PK = 2^(DATA_W-1)-1. lut[k] = round(PK*sin(2*pi*k/N)), k = 0..N/4-1.
- Sine: quadrant q = p[ADDR_W-1:ADDR_W-2], i = p[ADDR_W-3:0].
  - q0: lut[i].
  - q1: i==0 ? PK : lut[N/4-i].
  - q2: -lut[i].
  - q3: i==0 ? -PK : -lut[N/4-i].
- Square: p[ADDR_W-1]==0 ? PK : -PK.
- Sawtooth: p*2^(DATA_W-ADDR_W) - 2^(DATA_W-1).
- Triangle: t = p[ADDR_W-1] ? ~p[ADDR_W-2:0] : p[ADDR_W-2:0]; value = t*2^(DATA_W-ADDR_W+1) - 2^(DATA_W-1).
- Stages:
  - A: register p, mode, amp, valid.
  - B: LUT read, quadrant fold and mode select into raw, valid.
  - C: optional scaling into wave_out, out_valid.
- The pipeline has no backpressure; out_valid is a pure delayed copy of en.

## Timing
- Reset: acc=0, all stage valids=0, out_valid=0, wave_out=0. Reset flushes in-flight samples; out_valid=0 from the first cycle after the reset edge.
- Latency: a sample whose en=1 is in cycle n appears with out_valid=1 in cycle n+3.
- Throughput is one sample per cycle. en gaps produce out_valid gaps of equal length 3 cycles later. acc holds during gaps, so no phase is skipped.
- Without en, wave_out holds its last value.
- phase_clr with en=0: acc <= 0, no sample emitted.
- ftw=0: constant phase, the same sample repeats.

## Configuration
- WAVE_AMP_SCALE_EN defined:
  - Stage C computes wave_out = (raw * $signed({1'b0,amp})) >>> DATA_W, arithmetic shift, floor rounding.
  - Width is DATA_W+DATA_W+1 bits before truncation to DATA_W.
- Undefined:
  - amp is ignored; stage C registers raw unchanged.
  - Latency remains 3 cycles and no multiplier is inferred.

## Test plan
- Defaults, sine, ftw=2^22 (one LUT step/sample), en continuous from reset: the first out_valid is in cycle 3 with 0; samples k=256/512/768 = 32767/0/-32767; the sequence repeats every 1024 samples.
- Sawtooth and triangle, same ftw:
  - Sawtooth: k=0 -> -32768, k=1 -> -32704, k=1023 -> 32704.
  - Triangle: k=0 -> -32768, k=511 -> 32640, k=512 -> 32640, k=1023 -> -32768.
- Square with phase_off=256: the first 256 samples are 32767, the next 512 are -32767, then 32767 again.
- WAVE_AMP_SCALE_EN, sine, amp=16'h8000: k=256 -> 16383, k=768 -> -16384. Without the macro, same stimulus -> 32767/-32767.
- en low for 5 cycles mid-run: out_valid low for exactly 5 cycles, 3 cycles later; the next sample continues at k+1.
- phase_clr pulse with en=1 mid-run: the sample in that cycle uses phase 0, the next uses ftw.
- reset asserted mid-run: out_valid=0 and wave_out=0 the next cycle; after release the sequence restarts from k=0.
